// File: rtl/mant_div_pkg.sv
// ---------------------------------------------------------------------------
// mant_div_pkg
// Shared types and helpers for the iterative mantissa divider.
//   state_t    : divider control states (IDLE, RUN, DONE)
//   ceil_div   : integer ceiling division, gives the cycle count N
//   cnt_width  : step-counter width for a given cycle count (never below 1)
//   *_DEFAULT  : cycle count and counter width for the default configuration
// ---------------------------------------------------------------------------
package mant_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // A single-cycle divide still needs a one-bit counter so the RTL never
    // declares a zero-width vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MANT_W_DEFAULT = 24;
    localparam int STEPS_DEFAULT  = 1;
    localparam int N_DEFAULT      = ceil_div(MANT_W_DEFAULT + 1, STEPS_DEFAULT);
    localparam int CNT_W_DEFAULT  = $clog2(N_DEFAULT);

endpackage

// File: rtl/mant_div_step.sv
// ---------------------------------------------------------------------------
// mant_div_step
// One restoring-division step: compare, conditional subtract, shift.
//   residue_in  [MANT_W:0]   : partial residue entering this step
//   divisor     [MANT_W-1:0] : divisor B
//   last_step                : final step of the divide, the residue is left
//                              unshifted so it becomes the remainder
//   enable                   : step is active; when low the residue passes
//                              through and the quotient bit is 0
//   residue_out [MANT_W:0]   : partial residue leaving this step
//   q_bit                    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module mant_div_step #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W:0]   residue_in,
    input  logic [MANT_W-1:0] divisor,
    input  logic              last_step,
    input  logic              enable,
    output logic [MANT_W:0]   residue_out,
    output logic              q_bit
);

    logic [MANT_W:0] div_ext;
    logic [MANT_W:0] diff;
    logic [MANT_W:0] kept;
    logic            geq;

    // Residue is always below 2*B, so one extra bit above the divisor width
    // is enough for both the compare and the shifted result.
    always_comb begin
        div_ext     = {1'b0, divisor};
        geq         = (residue_in >= div_ext);
        diff        = residue_in - div_ext;
        kept        = geq ? diff : residue_in;
        residue_out = residue_in;
        q_bit       = 1'b0;
        if (enable) begin
            q_bit       = geq;
            residue_out = last_step ? kept : {kept[MANT_W-1:0], 1'b0};
        end
    end

endmodule

// File: rtl/mant_div_seq.sv
// ---------------------------------------------------------------------------
// mant_div_seq
// Iterative restoring mantissa divider: Q = floor(A*2^MANT_W / B),
// R = A*2^MANT_W - Q*B, computed STEPS_PER_CYCLE bits per clock.
// Optional feature macro: MANT_DIV_STICKY_EN (adds the sticky output).
//
// Parameters:
//   MANT_W          : mantissa width including hidden bit
//   STEPS_PER_CYCLE : restoring steps per clock, 1..MANT_W+1
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   dividend, divisor   : A and B, unsigned, A < 2*B expected
//   out_valid/out_ready : result handshake
//   quotient            : MANT_W+1 bits, MSB is the integer bit
//   remainder           : final residue
//   div_by_zero         : B was zero (Q all ones, R = A)
//   sticky              : remainder nonzero (MANT_DIV_STICKY_EN only)
// ---------------------------------------------------------------------------
module mant_div_seq
    import mant_div_pkg::*;
#(
    parameter int MANT_W          = 24,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   quotient,
    output logic [MANT_W-1:0] remainder,
    output logic              div_by_zero
`ifdef MANT_DIV_STICKY_EN
   ,output logic              sticky
`endif
);

    localparam int             N        = ceil_div(MANT_W + 1, STEPS_PER_CYCLE);
    localparam int             CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t            state;
    logic [MANT_W:0]   residue_q;
    logic [MANT_W-1:0] divisor_q;
    logic [MANT_W:0]   quot_q;
    logic [CNT_W-1:0]  cnt;
    logic              zero_div;

    logic [MANT_W:0]   res_final;
    logic [MANT_W:0]   quot_final;

    // Chain of combinational steps. Global step index cnt*S + j selects the
    // quotient bit; indices past MANT_W only occur in the last cycle and are
    // masked so surplus steps leave residue and quotient untouched.
    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
        logic [MANT_W:0] res_in;
        logic [MANT_W:0] res_out;
        logic [MANT_W:0] q_in;
        logic [MANT_W:0] q_out;
        logic            q_bit;
        logic            step_en;
        logic            step_last;
        int              step_idx;

        if (j == 0) begin : g_first
            assign res_in = residue_q;
            assign q_in   = quot_q;
        end else begin : g_next
            assign res_in = g_step[j-1].res_out;
            assign q_in   = g_step[j-1].q_out;
        end

        always_comb begin
            step_idx = int'(cnt) * STEPS_PER_CYCLE + j;
        end

        assign step_en   = (step_idx <= MANT_W);
        assign step_last = (step_idx == MANT_W);

        mant_div_step #(
            .MANT_W (MANT_W)
        ) u_step (
            .residue_in  (res_in),
            .divisor     (divisor_q),
            .last_step   (step_last),
            .enable      (step_en),
            .residue_out (res_out),
            .q_bit       (q_bit)
        );

        assign q_out = step_en ? {q_in[MANT_W-1:0], q_bit} : q_in;
    end

    assign res_final  = g_step[STEPS_PER_CYCLE-1].res_out;
    assign quot_final = g_step[STEPS_PER_CYCLE-1].q_out;

    // The working registers double as the result registers, so the outputs
    // come straight from flops.
    assign quotient  = quot_q;
    assign remainder = residue_q[MANT_W-1:0];

    // Control FSM and datapath registers. Divide by zero still passes through
    // one RUN cycle (counter preloaded to the last count) so that out_valid
    // rises one clock after acceptance; zero_div freezes the preset result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            residue_q   <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MANT_DIV_STICKY_EN
            sticky      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        residue_q <= {1'b0, dividend};
                        divisor_q <= divisor;
                        state     <= RUN;
                        if (divisor == '0) begin
                            quot_q   <= '1;
                            cnt      <= LAST_CNT;
                            zero_div <= 1'b1;
                        end else begin
                            quot_q   <= '0;
                            cnt      <= '0;
                            zero_div <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (!zero_div) begin
                        residue_q <= res_final;
                        quot_q    <= quot_final;
                    end
                    if (cnt == LAST_CNT) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        div_by_zero <= zero_div;
`ifdef MANT_DIV_STICKY_EN
                        sticky      <= !zero_div && (|res_final);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mant_div_seq
// Directed bench for mant_div_seq. Two instances share the operand and result
// handshakes: one with one step per clock (25-cycle divide) and one with five
// steps per clock (5-cycle divide). Both must produce identical results.
// ---------------------------------------------------------------------------
module tb_mant_div_seq;

    localparam int MW = 24;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [MW-1:0] dividend;
    logic [MW-1:0] divisor;
    logic          out_ready;

    logic          ir1, ov1, dbz1;
    logic [MW:0]   q1;
    logic [MW-1:0] r1;
    logic          ir5, ov5, dbz5;
    logic [MW:0]   q5;
    logic [MW-1:0] r5;
`ifdef MANT_DIV_STICKY_EN
    logic          st1, st5;
`endif

    int check_count = 0;
    int error_count = 0;

    mant_div_seq #(.MANT_W(MW), .STEPS_PER_CYCLE(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (ir1),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (ov1),
        .out_ready   (out_ready),
        .quotient    (q1),
        .remainder   (r1),
        .div_by_zero (dbz1)
`ifdef MANT_DIV_STICKY_EN
       ,.sticky      (st1)
`endif
    );

    mant_div_seq #(.MANT_W(MW), .STEPS_PER_CYCLE(5)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (ir5),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (ov5),
        .out_ready   (out_ready),
        .quotient    (q5),
        .remainder   (r5),
        .div_by_zero (dbz5)
`ifdef MANT_DIV_STICKY_EN
       ,.sticky      (st5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one divide to both instances, measure each latency, check the
    // results, hold off the consumer for hold_cycles, then consume.
    task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input logic [MW:0] exp_q, input logic [MW-1:0] exp_r,
                                 input logic exp_dbz, input logic exp_sticky,
                                 input int exp_lat1, input int exp_lat5,
                                 input int hold_cycles);
        int lat1;
        int lat5;
        lat1 = -1;
        lat5 = -1;
        @(negedge clk);
        checkOutput("in_ready1_before", 64'(ir1), 64'd1);
        checkOutput("in_ready5_before", 64'(ir5), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 60 && (lat1 < 0 || lat5 < 0); i++) begin
            @(posedge clk);
            #1;
            if (ov1 && lat1 < 0) lat1 = i;
            if (ov5 && lat5 < 0) lat5 = i;
        end
        checkOutput("latency_s1", 64'(lat1), 64'(exp_lat1));
        checkOutput("latency_s5", 64'(lat5), 64'(exp_lat5));
        checkOutput("quotient_s1", 64'(q1), 64'(exp_q));
        checkOutput("remainder_s1", 64'(r1), 64'(exp_r));
        checkOutput("dbz_s1", 64'(dbz1), 64'(exp_dbz));
        checkOutput("quotient_s5", 64'(q5), 64'(exp_q));
        checkOutput("remainder_s5", 64'(r5), 64'(exp_r));
        checkOutput("dbz_s5", 64'(dbz5), 64'(exp_dbz));
        checkOutput("in_ready1_busy", 64'(ir1), 64'd0);
`ifdef MANT_DIV_STICKY_EN
        checkOutput("sticky_s1", 64'(st1), 64'(exp_sticky));
        checkOutput("sticky_s5", 64'(st5), 64'(exp_sticky));
`else
        if (exp_sticky && exp_r == '0) $display("[TB] inconsistent sticky vector");
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid_s1", 64'(ov1), 64'd1);
            checkOutput("hold_quotient_s1", 64'(q1), 64'(exp_q));
            checkOutput("hold_remainder_s5", 64'(r5), 64'(exp_r));
            checkOutput("hold_in_ready_s1", 64'(ir1), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("consumed_valid_s1", 64'(ov1), 64'd0);
        checkOutput("consumed_valid_s5", 64'(ov5), 64'd0);
        checkOutput("idle_in_ready_s1", 64'(ir1), 64'd1);
        checkOutput("idle_in_ready_s5", 64'(ir5), 64'd1);
    endtask

    initial begin
        longint unsigned ra, rb, num, rq, rr, amax;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 64'(ov1), 64'd0);
        checkOutput("reset_in_ready", 64'(ir1), 64'd1);
        checkOutput("reset_quotient", 64'(q1), 64'd0);
        checkOutput("reset_remainder", 64'(r5), 64'd0);
        checkOutput("reset_dbz", 64'(dbz1), 64'd0);
        rst_n = 1'b1;

        $display("[TB] exact divide");
        applyStimulus(24'hC00000, 24'h800000, 25'h1800000, 24'h000000, 1'b0, 1'b0, 25, 5, 0);

        $display("[TB] inexact divide");
        applyStimulus(24'h800000, 24'hC00000, 25'h0AAAAAA, 24'h800000, 1'b0, 1'b1, 25, 5, 0);

        $display("[TB] divide by zero");
        applyStimulus(24'h800000, 24'h000000, 25'h1FFFFFF, 24'h800000, 1'b1, 1'b0, 1, 1, 0);

        $display("[TB] backpressure");
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 25'h1000000, 24'h000000, 1'b0, 1'b0, 25, 5, 10);

        $display("[TB] reset during run");
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 24'hC00000;
        divisor  = 24'h800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid_s1", 64'(ov1), 64'd0);
        checkOutput("midreset_out_valid_s5", 64'(ov5), 64'd0);
        checkOutput("midreset_in_ready_s1", 64'(ir1), 64'd1);
        checkOutput("midreset_quotient_s1", 64'(q1), 64'd0);
        checkOutput("midreset_remainder_s1", 64'(r1), 64'd0);
        checkOutput("midreset_quotient_s5", 64'(q5), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(24'h800000, 24'hC00000, 25'h0AAAAAA, 24'h800000, 1'b0, 1'b1, 25, 5, 0);

        $display("[TB] random legal operands");
        for (int k = 0; k < 8; k++) begin
            rb   = longint'($urandom_range(32'h00FFFFFF, 32'd1));
            amax = (2 * rb - 1 > 64'h00FFFFFF) ? 64'h00FFFFFF : 2 * rb - 1;
            ra   = longint'($urandom_range(32'(amax), 32'd0));
            num  = ra << MW;
            rq   = num / rb;
            rr   = num - rq * rb;
            applyStimulus(ra[MW-1:0], rb[MW-1:0], rq[MW:0], rr[MW-1:0], 1'b0,
                          (rr != 0), 25, 5, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
